// File: rtl/neuron_mac_master.sv
// neuron_mac_master: Avalon-MM master that fetches N image/weight pairs, accumulates their signed products and writes back one scaled result
module neuron_mac_master #(
    parameter int FRAC = 16,
    parameter bit RELU = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] control_base_addr,
    input  logic [7:0]  control_kernel_size,
    input  logic        control_start,
    input  logic        control_clear,
    output logic        control_done,
    output logic        img_read,
    output logic        img_write,
    output logic [29:0] img_address,
    output logic [31:0] img_writedata,
    input  logic [31:0] img_readdata,
    input  logic        img_waitrequest,
    output logic        weight_read,
    output logic        weight_write,
    output logic [29:0] weight_address,
    output logic [31:0] weight_writedata,
    input  logic [31:0] weight_readdata,
    input  logic        weight_waitrequest
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;

    state_t             r_state, w_state_n;
    logic [29:0]        r_base, r_img_addr, r_weight_addr;
    logic [7:0]         r_n, r_i, w_i1;
    logic signed [63:0] r_acc, w_prod, w_acc_n, w_s;
    logic [31:0]        r_img, r_wgt, r_wdata, w_result;
    logic               r_img_got, r_wgt_got, r_img_read, r_img_write, r_weight_read, r_done;
    logic               w_img_cap, w_wgt_cap, w_last, w_unused;

    assign w_unused  = ^control_base_addr[31:30];
    assign w_img_cap = r_img_read & ~img_waitrequest;
    assign w_wgt_cap = r_weight_read & ~weight_waitrequest;
    assign w_i1      = r_i + 8'd1;
    assign w_last    = (w_i1 == r_n);
    assign w_prod    = {{32{r_img[31]}}, r_img} * {{32{r_wgt[31]}}, r_wgt};
    assign w_acc_n   = r_acc + w_prod;
    assign w_s       = w_acc_n >>> FRAC;
    assign w_result  = (RELU && w_s[63]) ? 32'd0 :
                       (w_s[63:31] == {33{w_s[63]}}) ? w_s[31:0] :
                       w_s[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;

    assign control_done     = r_done;
    assign img_read         = r_img_read;
    assign img_write        = r_img_write;
    assign img_address      = r_img_addr;
    assign img_writedata    = r_wdata;
    assign weight_read      = r_weight_read;
    assign weight_write     = 1'b0;
    assign weight_address   = r_weight_addr;
    assign weight_writedata = 32'd0;

    // Next-state selection; a fetch leaves only once both words have been captured
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  w_state_n = control_start ? ((control_kernel_size != 8'd0) ? S_FETCH : S_WRITE) : S_IDLE;
            S_FETCH: w_state_n = ((r_img_got | w_img_cap) && (r_wgt_got | w_wgt_cap)) ? S_MAC : S_FETCH;
            S_MAC:   w_state_n = w_last ? S_WRITE : S_FETCH;
            S_WRITE: w_state_n = img_waitrequest ? S_WRITE : S_DONE;
            S_DONE:  w_state_n = control_clear ? S_IDLE : S_DONE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    // Datapath and registered bus commands, launched one cycle ahead of the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base        <= '0;
            r_n           <= '0;
            r_i           <= '0;
            r_acc         <= '0;
            r_img         <= '0;
            r_wgt         <= '0;
            r_img_got     <= 1'b0;
            r_wgt_got     <= 1'b0;
            r_img_read    <= 1'b0;
            r_img_write   <= 1'b0;
            r_weight_read <= 1'b0;
            r_img_addr    <= '0;
            r_weight_addr <= '0;
            r_wdata       <= '0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (control_start) begin
                    r_base        <= control_base_addr[29:0];
                    r_n           <= control_kernel_size;
                    r_i           <= '0;
                    r_acc         <= '0;
                    r_img_got     <= 1'b0;
                    r_wgt_got     <= 1'b0;
                    r_img_addr    <= control_base_addr[29:0];
                    r_weight_addr <= '0;
                    r_wdata       <= '0;
                    r_img_read    <= (control_kernel_size != 8'd0);
                    r_weight_read <= (control_kernel_size != 8'd0);
                    r_img_write   <= (control_kernel_size == 8'd0);
                end
                S_FETCH: begin
                    if (w_img_cap) begin
                        r_img      <= img_readdata;
                        r_img_read <= 1'b0;
                        r_img_got  <= 1'b1;
                    end
                    if (w_wgt_cap) begin
                        r_wgt         <= weight_readdata;
                        r_weight_read <= 1'b0;
                        r_wgt_got     <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc     <= w_acc_n;
                    r_img_got <= 1'b0;
                    r_wgt_got <= 1'b0;
                    if (w_last) begin
                        r_img_write <= 1'b1;
                        r_img_addr  <= r_base + {20'd0, r_n, 2'b00};
                        r_wdata     <= w_result;
                    end else begin
                        r_i           <= w_i1;
                        r_img_read    <= 1'b1;
                        r_weight_read <= 1'b1;
                        r_img_addr    <= r_base + {20'd0, w_i1, 2'b00};
                        r_weight_addr <= {20'd0, w_i1, 2'b00};
                    end
                end
                S_WRITE: if (!img_waitrequest) begin
                    r_img_write <= 1'b0;
                    r_done      <= 1'b1;
                end
                S_DONE: if (control_clear) r_done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_master.sv
// tb_neuron_mac_master: directed and randomized jobs against stalling Avalon slaves and an arithmetic reference model
module tb_neuron_mac_master;
    localparam int FRAC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] control_base_addr;
    logic [7:0]  control_kernel_size;
    logic        control_start, control_clear;
    logic        control_done, img_read, img_write, weight_read, weight_write;
    logic [29:0] img_address, weight_address;
    logic [31:0] img_writedata, weight_writedata;
    logic [31:0] img_readdata = '0, weight_readdata = '0;
    logic        img_waitrequest = 1'b0, weight_waitrequest = 1'b0;
    logic        d1_done, d1_img_read, d1_img_write, d1_weight_read, d1_weight_write;
    logic [29:0] d1_img_address, d1_weight_address;
    logic [31:0] d1_img_writedata, d1_weight_writedata;

    int          total = 0, bad = 0, viol = 0, maxw = 0;
    logic [31:0] iv[256], wv[256];
    logic [31:0] img_mem[int], wgt_mem[int];
    bit          stall_on = 1'b0;
    logic [29:0] stall_addr = '0;
    logic [29:0] rd_img_q[$], rd_wgt_q[$], wr_addr_q[$];
    logic [31:0] wr_d0_q[$], wr_d1_q[$];
    bit          ib = 1'b0, wb = 1'b0, iw = 1'b0;
    int          ic = 0, wc = 0;
    logic [29:0] ia, wa;
    logic [31:0] iwd;

    neuron_mac_master #(.FRAC(FRAC), .RELU(1'b1)) dut (
        .clk(clk), .reset(reset),
        .control_base_addr(control_base_addr), .control_kernel_size(control_kernel_size),
        .control_start(control_start), .control_clear(control_clear), .control_done(control_done),
        .img_read(img_read), .img_write(img_write), .img_address(img_address),
        .img_writedata(img_writedata), .img_readdata(img_readdata), .img_waitrequest(img_waitrequest),
        .weight_read(weight_read), .weight_write(weight_write), .weight_address(weight_address),
        .weight_writedata(weight_writedata), .weight_readdata(weight_readdata),
        .weight_waitrequest(weight_waitrequest)
    );

    neuron_mac_master #(.FRAC(FRAC), .RELU(1'b0)) dut_norelu (
        .clk(clk), .reset(reset),
        .control_base_addr(control_base_addr), .control_kernel_size(control_kernel_size),
        .control_start(control_start), .control_clear(control_clear), .control_done(d1_done),
        .img_read(d1_img_read), .img_write(d1_img_write), .img_address(d1_img_address),
        .img_writedata(d1_img_writedata), .img_readdata(img_readdata), .img_waitrequest(img_waitrequest),
        .weight_read(d1_weight_read), .weight_write(d1_weight_write), .weight_address(d1_weight_address),
        .weight_writedata(d1_weight_writedata), .weight_readdata(weight_readdata),
        .weight_waitrequest(weight_waitrequest)
    );

    always #5 clk = ~clk;

    // Slave models: random stalls per transaction, garbage data while stalled, logs of accepted transfers
    always @(negedge clk) begin
        if (reset) begin
            ib = 1'b0;
            wb = 1'b0;
            img_waitrequest = 1'b0;
            weight_waitrequest = 1'b0;
        end else begin
            if (img_read && img_write) viol++;
            if (img_read || img_write) begin
                if (!ib) begin
                    ib = 1'b1;
                    ic = $urandom_range(0, maxw);
                    ia = img_address;
                    iw = img_write;
                    iwd = img_writedata;
                end else if (img_address !== ia || img_write !== iw || (iw && img_writedata !== iwd)) viol++;
                if (ic == 0 && !(stall_on && img_address == stall_addr)) begin
                    img_waitrequest = 1'b0;
                    ib = 1'b0;
                    if (iw) begin
                        wr_addr_q.push_back(img_address);
                        wr_d0_q.push_back(img_writedata);
                        wr_d1_q.push_back(d1_img_writedata);
                    end else begin
                        img_readdata = img_mem.exists(int'(img_address)) ? img_mem[int'(img_address)] : 32'hDEAD_BEEF;
                        rd_img_q.push_back(img_address);
                    end
                end else begin
                    img_waitrequest = 1'b1;
                    img_readdata = $urandom;
                    if (ic > 0) ic--;
                end
            end else begin
                if (ib) viol++;
                ib = 1'b0;
                img_waitrequest = 1'($urandom_range(0, 1));
                img_readdata = $urandom;
            end
            if (weight_write) viol++;
            if (weight_read) begin
                if (!wb) begin
                    wb = 1'b1;
                    wc = $urandom_range(0, maxw);
                    wa = weight_address;
                end else if (weight_address !== wa) viol++;
                if (wc == 0) begin
                    weight_waitrequest = 1'b0;
                    wb = 1'b0;
                    weight_readdata = wgt_mem.exists(int'(weight_address)) ? wgt_mem[int'(weight_address)] : 32'hDEAD_BEEF;
                    rd_wgt_q.push_back(weight_address);
                end else begin
                    weight_waitrequest = 1'b1;
                    weight_readdata = $urandom;
                    wc--;
                end
            end else begin
                if (wb) viol++;
                wb = 1'b0;
                weight_waitrequest = 1'($urandom_range(0, 1));
                weight_readdata = $urandom;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int n, input bit relu);
        longint acc = 0;
        longint s;
        logic [31:0] r;
        for (int i = 0; i < n; i++) acc += longint'(signed'(iv[i])) * longint'(signed'(wv[i]));
        s = acc >>> FRAC;
        if (s > 64'sd2147483647) r = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) r = 32'h8000_0000;
        else r = s[31:0];
        if (relu && s < 0) r = 32'd0;
        return r;
    endfunction

    task automatic prep(input logic [31:0] base, input int n, input int w);
        logic [29:0] a;
        maxw = w;
        viol = 0;
        rd_img_q.delete();
        rd_wgt_q.delete();
        wr_addr_q.delete();
        wr_d0_q.delete();
        wr_d1_q.delete();
        img_mem.delete();
        wgt_mem.delete();
        for (int i = 0; i < n; i++) begin
            a = base[29:0] + 30'(4 * i);
            img_mem[int'(a)] = iv[i];
            wgt_mem[4 * i] = wv[i];
        end
    endtask

    task automatic run_job(input logic [31:0] base, input int n, input int w, input bit poke, input string tag);
        int k;
        logic [29:0] b;
        b = base[29:0];
        prep(base, n, w);
        @(negedge clk);
        control_base_addr = base;
        control_kernel_size = 8'(n);
        control_start = 1'b1;
        @(negedge clk);
        control_start = poke;
        if (poke) begin
            control_base_addr = 32'h1234_5670;
            control_kernel_size = 8'd7;
        end
        k = 0;
        while (!control_done && k < 3000) begin
            @(negedge clk);
            control_start = 1'b0;
            k++;
        end
        chk({tag, " done"}, 64'(control_done), 64'd1);
        if (w == 0) chk({tag, " latency"}, 64'(k), 64'(2 * n + 1));
        chk({tag, " nreads_img"}, 64'(rd_img_q.size()), 64'(n));
        chk({tag, " nreads_wgt"}, 64'(rd_wgt_q.size()), 64'(n));
        for (int i = 0; i < n && i < rd_img_q.size() && i < rd_wgt_q.size(); i++) begin
            chk({tag, " img_addr"}, 64'(rd_img_q[i]), 64'(30'(b + 30'(4 * i))));
            chk({tag, " wgt_addr"}, 64'(rd_wgt_q[i]), 64'(30'(4 * i)));
        end
        chk({tag, " nwrites"}, 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() > 0) begin
            chk({tag, " wr_addr"}, 64'(wr_addr_q[0]), 64'(30'(b + 30'(4 * n))));
            chk({tag, " wr_data_relu"}, 64'(wr_d0_q[0]), 64'(model(n, 1'b1)));
            chk({tag, " wr_data_raw"}, 64'(wr_d1_q[0]), 64'(model(n, 1'b0)));
        end
        chk({tag, " protocol"}, 64'(viol), 64'd0);
        control_start = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, " done_hold"}, 64'(control_done), 64'd1);
        chk({tag, " no_restart"}, 64'(rd_img_q.size() + wr_addr_q.size()), 64'(n + 1));
        control_start = 1'b0;
        control_clear = 1'b1;
        @(negedge clk);
        control_clear = 1'b0;
        chk({tag, " done_fall"}, 64'(control_done), 64'd0);
        @(negedge clk);
        chk({tag, " idle_quiet"}, 64'({img_read, img_write, weight_read}), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, 64'({control_done, img_read, img_write, weight_read, weight_write}), 64'd0);
        chk({tag, " addr"}, 64'({img_address, weight_address}), 64'd0);
        chk({tag, " data"}, 64'({img_writedata, weight_writedata}), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        int k;
        reset = 1'b1;
        control_base_addr = '0;
        control_kernel_size = '0;
        control_start = 1'b0;
        control_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        iv[0] = 32'h0001_0000; iv[1] = 32'h0002_0000; iv[2] = 32'hFFFF_0000;
        wv[0] = 32'h0001_0000; wv[1] = 32'h0001_0000; wv[2] = 32'h0001_0000;
        run_job(32'h100, 3, 0, 1'b0, "dot0");
        chk("dot0 model", 64'(model(3, 1'b1)), 64'h0002_0000);
        for (int rep = 0; rep < 4; rep++) run_job(32'h100, 3, 5, 1'b0, "dotwait");

        run_job(32'h200, 0, 0, 1'b0, "n0");
        run_job(32'h200, 0, 5, 1'b0, "n0wait");

        iv[0] = 32'hFFFE_0000; wv[0] = 32'h0001_0000;
        run_job(32'h40, 1, 0, 1'b0, "sign");

        iv[0] = 32'h7FFF_FFFF; iv[1] = 32'h7FFF_FFFF;
        wv[0] = 32'h7FFF_FFFF; wv[1] = 32'h7FFF_FFFF;
        run_job(32'h500, 2, 0, 1'b1, "sat");
        iv[0] = 32'h8000_0000; wv[0] = 32'h7FFF_FFFF;
        run_job(32'h80, 1, 2, 1'b0, "negsat");

        for (int i = 0; i < 3; i++) begin
            r = $urandom; iv[i] = {{12{r[19]}}, r[19:0]};
            r = $urandom; wv[i] = {{12{r[19]}}, r[19:0]};
        end
        run_job(32'hFFFF_FFF8, 3, 3, 1'b0, "wrap");

        for (int j = 0; j < 4; j++) begin
            k = $urandom_range(1, 12);
            for (int i = 0; i < k; i++) begin
                r = $urandom; iv[i] = {{12{r[19]}}, r[19:0]};
                r = $urandom; wv[i] = {{12{r[19]}}, r[19:0]};
            end
            run_job($urandom & 32'hFFFF_FFFC, k, 5, 1'b0, "rand");
        end

        for (int i = 0; i < 4; i++) begin
            iv[i] = 32'h0001_0000 * (i + 1);
            wv[i] = 32'h0000_8000;
        end
        prep(32'h300, 4, 0);
        stall_on = 1'b1;
        stall_addr = 30'h304;
        @(negedge clk);
        control_base_addr = 32'h300;
        control_kernel_size = 8'd4;
        control_start = 1'b1;
        @(negedge clk);
        control_start = 1'b0;
        k = 0;
        while (!(img_read && img_address == 30'h304) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("midrst reach", 64'(k < 100), 64'd1);
        repeat (2) @(negedge clk);
        chk("midrst stalled", 64'({img_read, img_address}), 64'({1'b1, 30'h304}));
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        reset = 1'b0;
        stall_on = 1'b0;
        @(negedge clk);
        chk("midrst idle", 64'({control_done, img_read, weight_read, img_write}), 64'd0);
        run_job(32'h300, 4, 2, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
